buffer_id_allocator: RTL and testbench

BUFFER_ID_ALLOCATOR -- requirements
Module: buffer_id_allocator

---
 rtl/buffer_id_allocator.sv | 210 +++++++++++++++++++++
 tb/tb_buffer_id_allocator.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/buffer_id_allocator.sv
// Buffer ID allocator: hands out IDs popped from an external FWFT free list
// through a one-entry alloc slot, tracks outstanding IDs in a bitmap, vets
// released IDs before returning them to the free list, and supports a
// drain/quiesce sequence that pushes an unclaimed slot ID back.
module buffer_id_allocator #(
  parameter int NUM_IDS  = 8,
  parameter int ID_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  // free-list read side (FWFT)
  input  logic                         fl_empty_n,
  output logic                         fl_read,
  input  logic [ID_WIDTH-1:0]          fl_dout,
  // free-list write side
  input  logic                         fl_full_n,
  output logic                         fl_write,
  output logic [ID_WIDTH-1:0]          fl_din,
  // allocation handshake
  output logic                         alloc_valid,
  input  logic                         alloc_ready,
  output logic [ID_WIDTH-1:0]          alloc_id,
  // release handshake
  input  logic                         free_valid,
  output logic                         free_ready,
  input  logic [ID_WIDTH-1:0]          free_id,
  // quiesce control and status
  input  logic                         drain_req,
  output logic                         drained,
  output logic [$clog2(NUM_IDS+1)-1:0] in_use_count,
  output logic                         err_range,
  output logic                         err_double_free
);

  localparam int IDX_W = (NUM_IDS > 1) ? $clog2(NUM_IDS) : 1;
  localparam int CNT_W = $clog2(NUM_IDS + 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FLUSH   = 2'd1,
    DRAINED = 2'd2
  } state_t;

  // An ID word is usable only if it names one of the NUM_IDS buffers.
  function automatic logic id_in_range(input logic [ID_WIDTH-1:0] id);
    return id < ID_WIDTH'(NUM_IDS);
  endfunction

  // Bitmap index of an in-range ID.
  function automatic logic [IDX_W-1:0] id_index(input logic [ID_WIDTH-1:0] id);
    return id[IDX_W-1:0];
  endfunction

  // Outstanding-ID counter update, saturating at both ends so a misbehaving
  // free list can never wrap the count.
  function automatic logic [CNT_W-1:0] count_next(input logic [CNT_W-1:0] count,
                                                  input logic             inc,
                                                  input logic             dec);
    logic [CNT_W-1:0] result;
    result = count;
    if (inc && !dec && (count != CNT_W'(NUM_IDS))) begin
      result = count + CNT_W'(1);
    end else if (dec && !inc && (count != '0)) begin
      result = count - CNT_W'(1);
    end
    return result;
  endfunction

  state_t                state;
  state_t                state_next;
  logic                  slot_valid;
  logic [ID_WIDTH-1:0]   slot_id;
  logic [NUM_IDS-1:0]    bitmap;
  logic [NUM_IDS-1:0]    bitmap_next;

  logic                  alloc_fire;
  logic                  flush_push;
  logic                  free_fire;
  logic                  free_in_range;
  logic                  free_bit;
  logic                  free_ok;
  logic                  free_bad_range;
  logic                  free_double;
  logic                  pop_in_range;
  logic                  pop_bad;

  assign alloc_id = slot_id;

  // Next state and handshake outputs; reset forces every strobe low while
  // free_ready keeps tracking free-list space.
  always_comb begin
    state_next  = state;
    alloc_valid = 1'b0;
    fl_read     = 1'b0;
    free_ready  = fl_full_n;
    flush_push  = 1'b0;
    drained     = 1'b0;
    if (!reset) begin
      unique case (state)
        RUN: begin
          alloc_valid = slot_valid;
          // Refill the slot whenever it is empty or being taken this cycle.
          fl_read     = fl_empty_n & (~slot_valid | alloc_ready);
          if (drain_req) begin
            state_next = FLUSH;
          end
        end
        FLUSH: begin
          // The write port is reserved for the slot return while it is pending.
          free_ready = fl_full_n & ~slot_valid;
          flush_push = slot_valid & fl_full_n;
          if (!slot_valid || flush_push) begin
            state_next = DRAINED;
          end
        end
        DRAINED: begin
          drained = (in_use_count == '0);
          if (!drain_req) begin
            state_next = RUN;
          end
        end
        default: begin
          state_next = RUN;
        end
      endcase
    end
  end

  assign alloc_fire     = alloc_valid & alloc_ready;
  assign free_fire      = free_valid & free_ready & ~reset;
  assign free_in_range  = id_in_range(free_id);
  assign free_bit       = free_in_range & bitmap[id_index(free_id)];
  assign free_ok        = free_fire & free_bit;
  assign free_bad_range = free_fire & ~free_in_range;
  assign free_double    = free_fire & free_in_range & ~free_bit;
  assign pop_in_range   = id_in_range(fl_dout);
  assign pop_bad        = fl_read & ~pop_in_range;

  // Only one source can write per cycle: frees are blocked while a flush
  // push is possible.
  assign fl_write = free_ok | flush_push;
  assign fl_din   = flush_push ? slot_id : free_id;

  // Bitmap update: the free is judged on the start-of-cycle bitmap, so a
  // free of the ID being allocated right now is seen as a double free.
  always_comb begin
    bitmap_next = bitmap;
    if (alloc_fire) begin
      bitmap_next[id_index(slot_id)] = 1'b1;
    end
    if (free_ok) begin
      bitmap_next[id_index(free_id)] = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Slot occupancy: loaded by an in-range pop, emptied by a handshake or a
  // flush push; an out-of-range pop leaves it empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_valid <= 1'b0;
    end else if (fl_read) begin
      slot_valid <= pop_in_range;
    end else if (alloc_fire || flush_push) begin
      slot_valid <= 1'b0;
    end
  end

  // Slot ID word captured on a valid pop.
  always_ff @(posedge clk) begin
    if (fl_read && pop_in_range) begin
      slot_id <= fl_dout;
    end
  end

  // In-use bitmap and outstanding count.
  always_ff @(posedge clk) begin
    if (reset) begin
      bitmap       <= '0;
      in_use_count <= '0;
    end else begin
      bitmap       <= bitmap_next;
      in_use_count <= count_next(in_use_count, alloc_fire, free_ok);
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_range       <= 1'b0;
      err_double_free <= 1'b0;
    end else begin
      err_range       <= err_range | free_bad_range | pop_bad;
      err_double_free <= err_double_free | free_double;
    end
  end

  // Free-list port sanity.
  a_write_has_space: assert property (@(posedge clk) disable iff (reset) fl_write |-> fl_full_n);
  a_read_has_word: assert property (@(posedge clk) disable iff (reset) fl_read |-> fl_empty_n);

endmodule

// File: tb/tb_buffer_id_allocator.sv
// Directed testbench for buffer_id_allocator with a behavioural FWFT free
// list and scoreboards for allocated IDs and free-list writes.
module tb_buffer_id_allocator;

  logic        clk = 1'b0;
  logic        reset;
  logic        fl_empty_n;
  logic        fl_read;
  logic [31:0] fl_dout;
  logic        fl_full_n;
  logic        fl_write;
  logic [31:0] fl_din;
  logic        alloc_valid;
  logic        alloc_ready;
  logic [31:0] alloc_id;
  logic        free_valid;
  logic        free_ready;
  logic [31:0] free_id;
  logic        drain_req;
  logic        drained;
  logic [3:0]  in_use_count;
  logic        err_range;
  logic        err_double_free;

  int checks = 0;
  int errors = 0;

  logic [31:0] fl_q[$];
  logic [31:0] exp_alloc[$];
  logic [31:0] exp_write[$];
  logic        cap_read = 1'b0;
  logic        cap_write = 1'b0;
  logic [31:0] cap_din = 32'd0;
  logic [31:0] rel_ids[7] = '{32'd0, 32'd1, 32'd3, 32'd4, 32'd6, 32'd7, 32'd2};

  buffer_id_allocator #(.NUM_IDS(8), .ID_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .fl_empty_n(fl_empty_n), .fl_read(fl_read), .fl_dout(fl_dout),
    .fl_full_n(fl_full_n), .fl_write(fl_write), .fl_din(fl_din),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_id(alloc_id),
    .free_valid(free_valid), .free_ready(free_ready), .free_id(free_id),
    .drain_req(drain_req), .drained(drained), .in_use_count(in_use_count),
    .err_range(err_range), .err_double_free(err_double_free)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fl_refresh();
    fl_empty_n = (fl_q.size() != 0);
    fl_dout    = (fl_q.size() != 0) ? fl_q[0] : 32'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: capture free-list strobes and check DUT output events.
  always @(negedge clk) begin
    cap_read  = fl_read;
    cap_write = fl_write;
    cap_din   = fl_din;
    if (alloc_valid && alloc_ready) begin
      checks++;
      assert (exp_alloc.size() != 0) else begin
        errors++;
        $error("FAIL alloc_unexpected: observed id %0d, expected no allocation", alloc_id);
      end
      if (exp_alloc.size() != 0) chk("alloc_id", alloc_id, exp_alloc.pop_front());
    end
    if (fl_write) begin
      chk("fl_write_space", 32'(fl_full_n), 32'd1);
      checks++;
      assert (exp_write.size() != 0) else begin
        errors++;
        $error("FAIL fl_write_unexpected: observed din %0d, expected no write", fl_din);
      end
      if (exp_write.size() != 0) chk("fl_din", fl_din, exp_write.pop_front());
    end
  end

  // Free-list model: commit the strobes of the cycle that just ended.
  always begin
    @(posedge clk);
    #1;
    if (cap_read && fl_q.size() != 0) fl_q.delete(0);
    if (cap_write) fl_q.push_back(cap_din);
    fl_refresh();
  end

  initial begin
    reset = 1'b1; fl_full_n = 1'b1; alloc_ready = 1'b0;
    free_valid = 1'b0; free_id = 32'd0; drain_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      fl_q.push_back(32'(i));
      exp_alloc.push_back(32'(i));
    end
    fl_refresh();

    // Reset state with a loaded free list
    @(negedge clk);
    chk("rst_fl_read", 32'(fl_read), 32'd0);
    chk("rst_alloc_valid", 32'(alloc_valid), 32'd0);
    chk("rst_drained", 32'(drained), 32'd0);
    chk("rst_free_ready", 32'(free_ready), 32'd1);
    chk("rst_count", 32'(in_use_count), 32'd0);
    chk("rst_err_range", 32'(err_range), 32'd0);
    chk("rst_err_dbl", 32'(err_double_free), 32'd0);

    // Allocate 0..7 back to back
    tick();
    reset = 1'b0; alloc_ready = 1'b1;
    @(negedge clk);
    chk("first_fl_read", 32'(fl_read), 32'd1);
    chk("first_alloc_valid", 32'(alloc_valid), 32'd0);
    tick();
    chk("alloc0_valid", 32'(alloc_valid), 32'd1);
    chk("alloc0_id", alloc_id, 32'd0);
    for (int i = 0; i < 20 && in_use_count != 4'd8; i++) tick();
    chk("full_count", 32'(in_use_count), 32'd8);
    chk("full_alloc_valid", 32'(alloc_valid), 32'd0);
    chk("full_fl_empty", 32'(fl_empty_n), 32'd0);

    // Out-of-range word from the free list
    fl_q.push_back(32'd12);
    fl_refresh();
    @(negedge clk);
    chk("pop12_read", 32'(fl_read), 32'd1);
    tick();
    chk("pop12_slot", 32'(alloc_valid), 32'd0);
    chk("pop12_err_range", 32'(err_range), 32'd1);
    chk("pop12_err_dbl", 32'(err_double_free), 32'd0);
    chk("pop12_count", 32'(in_use_count), 32'd8);
    alloc_ready = 1'b0;

    // Free 3, then free 3 again
    free_valid = 1'b1; free_id = 32'd3;
    exp_write.push_back(32'd3);
    @(negedge clk);
    chk("free3_ready", 32'(free_ready), 32'd1);
    chk("free3_write", 32'(fl_write), 32'd1);
    tick();
    chk("free3_count", 32'(in_use_count), 32'd7);
    @(negedge clk);
    chk("dbl3_write", 32'(fl_write), 32'd0);
    tick();
    free_valid = 1'b0;
    chk("dbl3_err", 32'(err_double_free), 32'd1);
    chk("dbl3_count", 32'(in_use_count), 32'd7);

    // Get id 4 into the slot behind id 3
    free_valid = 1'b1; free_id = 32'd4;
    exp_write.push_back(32'd4);
    tick();
    free_valid = 1'b0;
    chk("free4_count", 32'(in_use_count), 32'd6);
    chk("slot3_id", alloc_id, 32'd3);
    tick();
    alloc_ready = 1'b1;
    exp_alloc.push_back(32'd3);
    tick();
    chk("alloc3_count", 32'(in_use_count), 32'd7);
    chk("slot4_id", alloc_id, 32'd4);

    // Same-cycle allocation of 4 and free of 2
    exp_alloc.push_back(32'd4);
    free_valid = 1'b1; free_id = 32'd2;
    exp_write.push_back(32'd2);
    @(negedge clk);
    chk("sim_write", 32'(fl_write), 32'd1);
    chk("sim_alloc_valid", 32'(alloc_valid), 32'd1);
    tick();
    alloc_ready = 1'b0; free_valid = 1'b0;
    chk("sim_count", 32'(in_use_count), 32'd7);
    chk("sim_bit4", 32'(dut.bitmap[4]), 32'd1);
    chk("sim_bit2", 32'(dut.bitmap[2]), 32'd0);

    // Get id 5 into the slot
    tick();
    free_valid = 1'b1; free_id = 32'd5;
    exp_write.push_back(32'd5);
    tick();
    free_valid = 1'b0;
    tick();
    alloc_ready = 1'b1;
    exp_alloc.push_back(32'd2);
    tick();
    alloc_ready = 1'b0;
    chk("slot5_valid", 32'(alloc_valid), 32'd1);
    chk("slot5_id", alloc_id, 32'd5);
    chk("slot5_count", 32'(in_use_count), 32'd7);

    // Drain with the free list full for three FLUSH cycles
    drain_req = 1'b1; fl_full_n = 1'b0;
    @(negedge clk);
    chk("d0_free_ready", 32'(free_ready), 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("flush_alloc_valid", 32'(alloc_valid), 32'd0);
      chk("flush_free_ready", 32'(free_ready), 32'd0);
      chk("flush_write", 32'(fl_write), 32'd0);
      tick();
    end
    fl_full_n = 1'b1;
    exp_write.push_back(32'd5);
    @(negedge clk);
    chk("push5_write", 32'(fl_write), 32'd1);
    chk("push5_free_ready", 32'(free_ready), 32'd0);
    tick();
    @(negedge clk);
    chk("drn_drained", 32'(drained), 32'd0);
    chk("drn_alloc_valid", 32'(alloc_valid), 32'd0);
    chk("drn_fl_read", 32'(fl_read), 32'd0);
    chk("drn_free_ready", 32'(free_ready), 32'd1);
    tick();
    foreach (rel_ids[k]) begin
      free_valid = 1'b1; free_id = rel_ids[k];
      exp_write.push_back(rel_ids[k]);
      tick();
    end
    free_valid = 1'b0;
    @(negedge clk);
    chk("drn_count", 32'(in_use_count), 32'd0);
    chk("drn_drained_done", 32'(drained), 32'd1);

    // Back to RUN, allocate four IDs and leave one in the slot
    tick();
    drain_req = 1'b0; alloc_ready = 1'b1;
    exp_alloc.push_back(32'd5); exp_alloc.push_back(32'd0);
    exp_alloc.push_back(32'd1); exp_alloc.push_back(32'd3);
    for (int i = 0; i < 20 && in_use_count != 4'd4; i++) tick();
    alloc_ready = 1'b0;
    chk("run_count", 32'(in_use_count), 32'd4);
    @(negedge clk);
    chk("run_slot_valid", 32'(alloc_valid), 32'd1);
    chk("run_slot_id", alloc_id, 32'd4);
    tick();

    // Reset mid-operation; the free list is reinitialised (empty) too
    reset = 1'b1; fl_full_n = 1'b0; free_valid = 1'b1; free_id = 32'd0;
    fl_q.delete();
    fl_refresh();
    @(negedge clk);
    chk("rst2_fl_read", 32'(fl_read), 32'd0);
    chk("rst2_fl_write", 32'(fl_write), 32'd0);
    chk("rst2_alloc_valid", 32'(alloc_valid), 32'd0);
    chk("rst2_drained", 32'(drained), 32'd0);
    chk("rst2_free_ready", 32'(free_ready), 32'd0);
    tick();
    fl_full_n = 1'b1;
    chk("rst2_count", 32'(in_use_count), 32'd0);
    chk("rst2_err_range", 32'(err_range), 32'd0);
    chk("rst2_err_dbl", 32'(err_double_free), 32'd0);
    chk("rst2_slot", 32'(dut.slot_valid), 32'd0);
    chk("rst2_bitmap", 32'(dut.bitmap), 32'd0);
    @(negedge clk);
    chk("rst2_free_ready_hi", 32'(free_ready), 32'd1);
    chk("rst2_fl_write_hi", 32'(fl_write), 32'd0);
    tick();

    // Out-of-range free, then a free of a never-allocated ID
    reset = 1'b0; free_id = 32'd9;
    @(negedge clk);
    chk("free9_write", 32'(fl_write), 32'd0);
    chk("free9_ready", 32'(free_ready), 32'd1);
    tick();
    free_id = 32'd0;
    chk("free9_err_range", 32'(err_range), 32'd1);
    chk("free9_err_dbl", 32'(err_double_free), 32'd0);
    chk("free9_count", 32'(in_use_count), 32'd0);
    @(negedge clk);
    chk("free0_write", 32'(fl_write), 32'd0);
    tick();
    free_valid = 1'b0;
    chk("free0_err_dbl", 32'(err_double_free), 32'd1);

    chk("sb_alloc_left", 32'(exp_alloc.size()), 32'd0);
    chk("sb_write_left", 32'(exp_write.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
